// File: rtl/pipe_addsub_acc_if.sv
// Operand/result bundle for pipe_addsub_acc: op request in, result and accumulator out.
// The master side issues operands; the slave side (the adder) returns results.
interface pipe_addsub_acc_if #(
   parameter int W     = 31,
   parameter int ACC_W = 40
);
   logic             in_vld;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [1:0]       in_op;
   logic             out_vld;
   logic [W:0]       res;
   logic [ACC_W-1:0] acc;
   logic             acc_ovf;

   modport master (
      output in_vld, in_a, in_b, in_op,
      input  out_vld, res, acc, acc_ovf
   );

   modport slave (
      input  in_vld, in_a, in_b, in_op,
      output out_vld, res, acc, acc_ovf
   );
endinterface

// File: rtl/pipe_addsub_acc.sv
// Carry-pipelined signed add/sub over SEGS segments feeding a wide signed accumulator.
// Build option ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module pipe_addsub_acc #(
   parameter int W     = 31,
   parameter int SEGS  = 2,
   parameter int ACC_W = 40
) (
   input logic               clk,
   input logic               rst_n,
   pipe_addsub_acc_if.slave  bus
);
   localparam int RW  = W + 1;
   localparam int SW  = (RW + SEGS - 1) / SEGS;
   localparam int TW  = SW * SEGS;
   localparam int PAD = TW - RW;

   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ACC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   logic         vld0_reg;
   logic [W-1:0] a0_reg;
   logic [W-1:0] b0_reg;
   logic [1:0]   op0_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld0_reg <= 1'b0;
         a0_reg   <= '0;
         b0_reg   <= '0;
         op0_reg  <= '0;
      end else begin
         vld0_reg <= bus.in_vld;
         a0_reg   <= bus.in_a;
         b0_reg   <= bus.in_b;
         op0_reg  <= bus.in_op;
      end
   end

   // View j = operands after j segments consumed. Pending operand bits shift down so the
   // next segment is always at the bottom; finished sum segments shift in from the top.
   logic [SEGS-1:0][TW-1:0] x_v;
   logic [SEGS-1:0][TW-1:0] y_v;
   logic [SEGS-1:0][TW-1:0] s_v;
   logic [SEGS-1:0]         c_v;
   logic [SEGS-1:0]         vld_v;
   logic [SEGS-1:0][1:0]    op_v;

   logic          sub0;
   logic [TW-1:0] a_ext;
   logic [TW-1:0] b_ext;

   // Padding sits below the LSB; for SUB the inverted pad is all ones, so the carry-in
   // ripples through it into bit 0 of the real operand.
   assign sub0     = (op0_reg == OP_SUB);
   assign a_ext    = TW'($signed(a0_reg)) << PAD;
   assign b_ext    = TW'($signed(b0_reg)) << PAD;
   assign x_v[0]   = a_ext;
   assign y_v[0]   = sub0 ? ~b_ext : b_ext;
   assign s_v[0]   = '0;
   assign c_v[0]   = sub0;
   assign vld_v[0] = vld0_reg;
   assign op_v[0]  = op0_reg;

   for (genvar gi = 1; gi < SEGS; gi++) begin : g_stage
      logic [SW:0]   seg_sum;
      logic [TW-1:0] x_reg;
      logic [TW-1:0] y_reg;
      logic [TW-1:0] s_reg;
      logic          c_reg;
      logic          vld_reg;
      logic [1:0]    op_reg;

      assign seg_sum = {1'b0, x_v[gi-1][SW-1:0]} + {1'b0, y_v[gi-1][SW-1:0]}
                     + (SW+1)'(c_v[gi-1]);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            x_reg   <= '0;
            y_reg   <= '0;
            s_reg   <= '0;
            c_reg   <= 1'b0;
            vld_reg <= 1'b0;
            op_reg  <= '0;
         end else begin
            x_reg   <= x_v[gi-1] >> SW;
            y_reg   <= y_v[gi-1] >> SW;
            s_reg   <= (s_v[gi-1] >> SW) | (TW'(seg_sum[SW-1:0]) << (TW - SW));
            c_reg   <= seg_sum[SW];
            vld_reg <= vld_v[gi-1];
            op_reg  <= op_v[gi-1];
         end
      end

      assign x_v[gi]   = x_reg;
      assign y_v[gi]   = y_reg;
      assign s_v[gi]   = s_reg;
      assign c_v[gi]   = c_reg;
      assign vld_v[gi] = vld_reg;
      assign op_v[gi]  = op_reg;
   end

   logic [TW-1:0] top_sum;
   logic [TW-1:0] fin_sum;
   logic [RW-1:0] res_next;

   // Only the low SW bits of top_sum survive the shift; its carry-out is dropped.
   assign top_sum  = x_v[SEGS-1] + y_v[SEGS-1] + TW'(c_v[SEGS-1]);
   assign fin_sum  = (s_v[SEGS-1] >> SW) | (top_sum << (TW - SW));
   assign res_next = RW'(fin_sum >> PAD);

   logic               out_vld_reg;
   logic [RW-1:0]      res_reg;
   logic [ACC_W-1:0]   acc_reg;
   logic               ovf_reg;
   logic [ACC_W-1:0]   res_ext;
   logic [ACC_W-1:0]   acc_sum;
   logic               sum_ovf;
   logic [ACC_W-1:0]   acc_next;
   logic               ovf_next;

   assign res_ext = ACC_W'($signed(res_next));
   assign acc_sum = acc_reg + res_ext;
   assign sum_ovf = (acc_reg[ACC_W-1] == res_ext[ACC_W-1])
                 && (acc_sum[ACC_W-1] != acc_reg[ACC_W-1]);

   always_comb begin
      acc_next = acc_reg;
      ovf_next = ovf_reg;
      if (op_v[SEGS-1] == OP_CLR) begin
         acc_next = '0;
         ovf_next = 1'b0;
      end else if (op_v[SEGS-1] == OP_ACC) begin
         acc_next = acc_sum;
         if (sum_ovf) begin
            ovf_next = 1'b1;
`ifdef ACC_SAT_EN
            // On overflow both addends share the sign of the true sum.
            acc_next = res_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_reg <= 1'b0;
         res_reg     <= '0;
         acc_reg     <= '0;
         ovf_reg     <= 1'b0;
      end else begin
         out_vld_reg <= vld_v[SEGS-1];
         if (vld_v[SEGS-1]) begin
            res_reg <= res_next;
            acc_reg <= acc_next;
            ovf_reg <= ovf_next;
         end
      end
   end

   assign bus.out_vld = out_vld_reg;
   assign bus.res     = res_reg;
   assign bus.acc     = acc_reg;
   assign bus.acc_ovf = ovf_reg;
endmodule

// File: tb/tb_pipe_addsub_acc.sv
// Bench for pipe_addsub_acc: four builds (SEGS=2/1/4 at ACC_W=40, SEGS=2 at ACC_W=33) share
// one stimulus stream; a scoreboard per build checks result, accumulator, flag and latency.
module tb_pipe_addsub_acc;
   localparam int W = 31;
   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         vld_d = 1'b0;
   logic [W-1:0] a_d = '0;
   logic [W-1:0] b_d = '0;
   logic [1:0]   op_d = '0;

   pipe_addsub_acc_if #(.W(W), .ACC_W(40)) bus2 ();
   pipe_addsub_acc_if #(.W(W), .ACC_W(40)) bus1 ();
   pipe_addsub_acc_if #(.W(W), .ACC_W(40)) bus4 ();
   pipe_addsub_acc_if #(.W(W), .ACC_W(33)) bus33 ();

   assign bus2.in_vld = vld_d;  assign bus2.in_a = a_d;  assign bus2.in_b = b_d;  assign bus2.in_op = op_d;
   assign bus1.in_vld = vld_d;  assign bus1.in_a = a_d;  assign bus1.in_b = b_d;  assign bus1.in_op = op_d;
   assign bus4.in_vld = vld_d;  assign bus4.in_a = a_d;  assign bus4.in_b = b_d;  assign bus4.in_op = op_d;
   assign bus33.in_vld = vld_d; assign bus33.in_a = a_d; assign bus33.in_b = b_d; assign bus33.in_op = op_d;

   pipe_addsub_acc #(.W(W), .SEGS(2), .ACC_W(40)) dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
   pipe_addsub_acc #(.W(W), .SEGS(1), .ACC_W(40)) dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
   pipe_addsub_acc #(.W(W), .SEGS(4), .ACC_W(40)) dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
   pipe_addsub_acc #(.W(W), .SEGS(2), .ACC_W(33)) dut33 (.clk(clk), .rst_n(rst_n), .bus(bus33));

   typedef struct { longint res; longint acc; bit ovf; int cyc; } exp_t;
   typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [1:0] op; longint res; } vec_t;

   exp_t   q [4][$];
   int     lat  [4] = '{3, 2, 5, 3};
   int     accw [4] = '{40, 40, 40, 33};
   longint macc [4];
   bit     movf [4];
   longint last_res [4];
   int     checks = 0;
   int     passes = 0;
   int     fails  = 0;
   int     cyc    = 0;
   vec_t   tbl [10];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input longint act, input longint req);
      checks++;
      if (act == req) passes++;
      else begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endfunction

   function automatic longint ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [1:0] op);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return (op == SUB) ? sa - sb : sa + sb;
   endfunction

   // Accumulator reference: exact 64-bit sum, then range-checked against the ACC width.
   function automatic void acc_model(input int id, input longint r, input logic [1:0] op);
      longint s, mx, mn, span;
      span = longint'(1) << accw[id];
      mx   = (longint'(1) << (accw[id] - 1)) - 1;
      mn   = -mx - 1;
      if (op == CLR) begin
         macc[id] = 0;
         movf[id] = 1'b0;
      end else if (op == ACC) begin
         s = macc[id] + r;
         if (s > mx || s < mn) begin
            movf[id] = 1'b1;
`ifdef ACC_SAT_EN
            s = (s > mx) ? mx : mn;
`else
            s = s & (span - 1);
            if (s > mx) s = s - span;
`endif
         end
         macc[id] = s;
      end
   endfunction

   task automatic issue(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input longint r);
      exp_t e;
      @(negedge clk);
      vld_d = v; a_d = a; b_d = b; op_d = op;
      if (v) begin
         for (int id = 0; id < 4; id++) begin
            acc_model(id, r, op);
            e.res = r; e.acc = macc[id]; e.ovf = movf[id]; e.cyc = cyc;
            q[id].push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(1'b0, '0, '0, ADD, 0);
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
      issue(1'b1, a, b, o, ref_res(a, b, o));
   endtask

   task automatic flush_model();
      for (int id = 0; id < 4; id++) begin
         q[id].delete();
         macc[id] = 0; movf[id] = 1'b0; last_res[id] = 0;
      end
   endtask

   task automatic mon(input int id, input bit vld, input longint r, input longint ac, input bit ov);
      exp_t  e;
      string nm;
      nm = $sformatf("dut%0d", id);
      if (vld) begin
         chk({nm, " out_vld with pending op"}, longint'(q[id].size() != 0), 1);
         if (q[id].size() != 0) begin
            e = q[id].pop_front();
            chk({nm, " latency"}, longint'(cyc - e.cyc), longint'(lat[id]));
            chk({nm, " res"}, r, e.res);
            chk({nm, " acc"}, ac, e.acc);
            chk({nm, " acc_ovf"}, longint'(ov), longint'(e.ovf));
            last_res[id] = e.res;
            if (id == 0)
               $display("txn cyc=%0d res=%0d acc=%0d ovf=%0b", cyc, r, ac, ov);
         end
      end else begin
         chk({nm, " res hold"}, r, last_res[id]);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, bus2.out_vld, longint'($signed(bus2.res)), longint'($signed(bus2.acc)), bus2.acc_ovf);
         mon(1, bus1.out_vld, longint'($signed(bus1.res)), longint'($signed(bus1.acc)), bus1.acc_ovf);
         mon(2, bus4.out_vld, longint'($signed(bus4.res)), longint'($signed(bus4.acc)), bus4.acc_ovf);
         mon(3, bus33.out_vld, longint'($signed(bus33.res)), longint'($signed(bus33.acc)), bus33.acc_ovf);
      end
   end

   initial begin
      tbl[0] = '{31'h3FFF_FFFF, 31'h0000_0001, ADD, 64'sd1073741824};
      tbl[1] = '{31'h4000_0000, 31'h3FFF_FFFF, SUB, -64'sd2147483647};
      tbl[2] = '{31'h3FFF_FFFF, 31'h3FFF_FFFF, ADD, 64'sd2147483646};
      tbl[3] = '{31'h4000_0000, 31'h4000_0000, ADD, -64'sd2147483648};
      tbl[4] = '{31'h0000_0000, 31'h4000_0000, SUB, 64'sd1073741824};
      tbl[5] = '{31'h7FFF_FFFF, 31'h7FFF_FFFF, ACC, -64'sd2};
      tbl[6] = '{31'd5,         31'd7,         CLR, 64'sd12};
      tbl[7] = '{31'd5,         31'd7,         SUB, -64'sd2};
      tbl[8] = '{31'h0000_FFFF, 31'h0000_0001, ACC, 64'sd65536};
      tbl[9] = '{31'h7FFF_FFFF, 31'h7FFF_FFFF, SUB, 64'sd0};
      flush_model();

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset out_vld", longint'(bus2.out_vld), 0);
      chk("reset res", longint'(bus2.res), 0);
      chk("reset acc", longint'(bus2.acc), 0);
      chk("reset acc_ovf", longint'(bus2.acc_ovf), 0);
      rst_n = 1'b1;
      idle(2);

      // Vector table, back to back
      for (int i = 0; i < 10; i++) issue(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].res);
      idle(8);

      // Async reset with two ops in flight
      op(31'd100, 31'd23, ADD);
      op(31'd7, 31'd9, ACC);
      @(posedge clk);
      #2 rst_n = 1'b0;
      vld_d = 1'b0;
      #1;
      chk("async rst dut2 res", longint'(bus2.res), 0);
      chk("async rst dut2 acc", longint'(bus2.acc), 0);
      chk("async rst dut1 out_vld", longint'(bus1.out_vld), 0);
      chk("async rst dut1 res", longint'(bus1.res), 0);
      chk("async rst dut4 acc", longint'(bus4.acc), 0);
      flush_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(8);
      op(31'd40, 31'd2, ADD);
      idle(8);

      // Eight back-to-back ACC ops, then CLR
      op(31'd0, 31'd0, CLR);
      for (int i = 0; i < 8; i++) op(31'd1000, 31'h7FFF_FFFF, ACC);
      idle(8);
      chk("acc stream dut2", longint'($signed(bus2.acc)), 64'sd7992);
      chk("acc stream dut4", longint'($signed(bus4.acc)), 64'sd7992);
      op(31'd3, 31'd4, CLR);
      idle(8);
      chk("clr acc", longint'($signed(bus2.acc)), 0);
      chk("clr acc_ovf", longint'(bus2.acc_ovf), 0);

      // 33-bit accumulator overflows on the third large ACC
      op(31'd0, 31'd0, CLR);
      op(31'h3FFF_FFFF, 31'h3FFF_FFFF, ACC);
      op(31'h3FFF_FFFF, 31'h3FFF_FFFF, ACC);
      idle(8);
      chk("acc33 no ovf after 2", longint'(bus33.acc_ovf), 0);
      op(31'h3FFF_FFFF, 31'h3FFF_FFFF, ACC);
      idle(8);
      chk("acc33 ovf after 3", longint'(bus33.acc_ovf), 1);
`ifdef ACC_SAT_EN
      chk("acc33 saturated", longint'($signed(bus33.acc)), 64'sd4294967295);
`else
      chk("acc33 wrapped", longint'($signed(bus33.acc)), -64'sd2147483654);
`endif
      chk("acc40 no ovf", longint'(bus2.acc_ovf), 0);
      chk("acc40 value", longint'($signed(bus2.acc)), 64'sd6442450938);
      op(31'h3FFF_FFFF, 31'd1, ACC);
      op(31'd0, 31'd0, CLR);
      idle(8);
      chk("acc33 ovf cleared", longint'(bus33.acc_ovf), 0);

      // Alternating valid/idle random traffic
      for (int i = 0; i < 10000; i++) begin
         if (i % 2 == 0) begin
            logic [W-1:0] ra, rb;
            logic [1:0]   ro;
            int           k;
            k  = $urandom_range(0, 7);
            ra = (k == 0) ? 31'h3FFF_FFFF : (k == 1) ? 31'h4000_0000 : W'($urandom);
            k  = $urandom_range(0, 7);
            rb = (k == 0) ? 31'h3FFF_FFFF : (k == 1) ? 31'h4000_0000 : W'($urandom);
            ro = ($urandom_range(0, 15) == 0) ? CLR : 2'($urandom_range(0, 2));
            op(ra, rb, ro);
         end else begin
            idle(1);
         end
      end
      idle(10);

      for (int id = 0; id < 4; id++)
         chk($sformatf("dut%0d drained", id), longint'(q[id].size()), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
